mips_input_port: RTL and testbench
==================================

// Module: mips_input_port
// PURPOSE
//  Memory-mapped input interface for Mips32. It is the responder to the core's
//  data-memory load/store initiator.
//  An external producer pushes 32-bit words over a valid/ready handshake into a small FIFO.
//  The core pops words by loading from DATA_ADDR and polls/clears status at STAT_ADDR.
//  Sits beside data memory; the top muxes ReadData in when ReadHit is high.
// PARAMETERS
//  DEPTH      4             FIFO entries; power of two, 2..16
//  DATA_ADDR  32'h0000_FF00 load address: pop FIFO head
//  STAT_ADDR  32'h0000_FF04 load address: status word; store: clear sticky bits
//  IRQ_LEVEL  2             fill level that raises Irq (used only with INPUT_IRQ_EN)
// PORTS
//  Clk        in   1   rising-edge clock, shared with ProcessUnit
//  Reset      in   1   asynchronous, active-high reset
//  InData     in   32  producer data word
//  InValid    in   1   producer offers InData this cycle
//  InReady    out  1   port accepts a word this cycle
//  Address    in   32  core data-memory address (ALU result)
//  MemRead    in   1   core load strobe (from ControlUnit)
//  MemWrite   in   1   core store strobe (from ControlUnit)
//  WriteData  in   32  core store data
//  ReadData   out  32  load data; 0 when ReadHit is low
//  ReadHit    out  1   MemRead high and Address is DATA_ADDR or STAT_ADDR
//  Irq        out  1   fill-level interrupt (present only with INPUT_IRQ_EN)
// BEHAVIOUR
//  - Reset (async): wr_ptr, rd_ptr and count go to 0; Underflow and Irq go to 0.
//    FIFO storage is not cleared. While Reset is high, InReady is 0.
//  - count width is $clog2(DEPTH+1). Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
//  - InReady = !Reset && (count != DEPTH). Comb from registered count; no dependence on InValid.
//  - Push: on the edge where InValid && InReady, store InData at wr_ptr, wr_ptr++.
//  - Pop: on the edge where MemRead && Address==DATA_ADDR && count!=0, rd_ptr++.
//  - Read path is combinational, for the single-cycle core:
//      DATA_ADDR hit, not empty: ReadData = mem[rd_ptr].
//      DATA_ADDR hit, empty: ReadData = 0, no pop; Underflow is set at the edge.
//      STAT_ADDR hit: ReadData = {16'b0, 8'(count), 5'b0, Underflow, full, empty}.
//      No hit: ReadData = 0, ReadHit = 0.
//  - Store to STAT_ADDR (MemWrite high): WriteData[2]=1 clears Underflow; other bits are ignored.
//    A store to DATA_ADDR is ignored.
//  - Same-edge push and pop, count in 1..DEPTH-1: both happen and count is unchanged.
//  - At full (count==DEPTH), InReady is 0, so no push. A pop that edge still happens:
//    count becomes DEPTH-1 and InReady rises on the next cycle.
//  - At empty, a push and a load on the same edge: the load returns 0 and sets Underflow.
//    There is no bypass; the pushed word is read on a later load.
//  - Underflow set and clear on the same edge: set wins.
//  - MemRead and MemWrite are mutually exclusive from ControlUnit. If both are high,
//    the read path is evaluated and the store is ignored.
//  - Reset mid-transfer: an in-flight word is dropped. The producer must re-offer it
//    after Reset falls.
// CONFIGURATION
//  INPUT_IRQ_EN defined:
//    Irq is a registered output, updated every edge: Irq <= (count_next >= IRQ_LEVEL) | Underflow_next.
//    It drops on the edge where a pop or clear takes the condition false.
//  INPUT_IRQ_EN undefined:
//    the Irq port and its logic are absent, and IRQ_LEVEL is unused.
// TESTING
//  1 Reset, then push 32'hA5A5_0001..0004 (DEPTH=4) -> InReady=0 after the 4th; status reads 32'h0000_0402.
//  2 From full, load DATA_ADDR x4 -> returns 0001..0004 in order; status 32'h0000_0001; InReady=1.
//  3 Load DATA_ADDR while empty -> ReadData=0, no pointer move; status bit2=1.
//    Store 32'h4 to STAT_ADDR -> bit2=0.
//  4 count=2, push and pop on the same edge -> count stays 2, FIFO order preserved.
//    At full with InValid held high, a pop accepts exactly one word on the next cycle.
//  5 Assert Reset asynchronously mid-push with count=3 -> count=0 and InReady=0 immediately;
//    the next load after release returns 0 and sets Underflow.
//  6 INPUT_IRQ_EN, IRQ_LEVEL=2 -> Irq rises on the edge after the 2nd push and falls after
//    the pop to count=1. Without the macro, the design elaborates with no Irq port.

Source files
------------

// File: rtl/mips_input_port.sv
// Memory-mapped input FIFO for the Mips32 data bus: producer pushes, core pops via loads.
// Optional fill-level interrupt output is built only when INPUT_IRQ_EN is defined.
module mips_input_port #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] DATA_ADDR = 32'h0000_FF00,
    parameter logic [31:0] STAT_ADDR = 32'h0000_FF04,
    parameter int          IRQ_LEVEL = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] InData,
    input  logic        InValid,
    output logic        InReady,
    input  logic [31:0] Address,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
`ifdef INPUT_IRQ_EN
    output logic        Irq,
`endif
    output logic        ReadHit
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          underflow_q, underflow_d;

    logic data_hit, stat_hit, stat_wr;
    logic empty, full, push, pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == DEPTH_C);
    assign data_hit = MemRead && (Address == DATA_ADDR);
    assign stat_hit = MemRead && (Address == STAT_ADDR);
    // A simultaneous MemRead suppresses the store.
    assign stat_wr  = MemWrite && !MemRead && (Address == STAT_ADDR);

    assign InReady  = !Reset && !full;
    assign push     = InValid && InReady;
    assign pop      = data_hit && !empty;
    assign ReadHit  = data_hit || stat_hit;

    always_comb begin
        ReadData = 32'h0;
        if (data_hit && !empty) begin
            ReadData = mem_q[rd_ptr_q];
        end else if (stat_hit) begin
            ReadData = {16'b0, 8'(count_q), 5'b0, underflow_q, full, empty};
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        underflow_d = underflow_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // Set has priority over a same-edge clear.
        if (stat_wr && WriteData[2]) underflow_d = 1'b0;
        if (data_hit && empty)       underflow_d = 1'b1;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (push) mem_q[wr_ptr_q] <= InData;
    end

`ifdef INPUT_IRQ_EN
    logic irq_q;
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) irq_q <= 1'b0;
        else       irq_q <= (count_d >= CW'(IRQ_LEVEL)) || underflow_d;
    end
    assign Irq = irq_q;
`endif

    logic unused_wdata;
    assign unused_wdata = ^{WriteData[31:3], WriteData[1:0]};

endmodule

// File: tb/tb_mips_input_port.sv
// Directed bench for mips_input_port: fill, drain, underflow, same-edge traffic, reset, irq.
module tb_mips_input_port;

    localparam logic [31:0] DATA_ADDR = 32'h0000_FF00;
    localparam logic [31:0] STAT_ADDR = 32'h0000_FF04;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] InData = '0;
    logic        InValid = 1'b0;
    logic        InReady;
    logic [31:0] Address = '0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] WriteData = '0;
    logic [31:0] ReadData;
    logic        ReadHit;
`ifdef INPUT_IRQ_EN
    logic        Irq;
`endif

    int checks = 0;
    int passed = 0;

    mips_input_port dut (
        .Clk(Clk), .Reset(Reset), .InData(InData), .InValid(InValid), .InReady(InReady),
        .Address(Address), .MemRead(MemRead), .MemWrite(MemWrite), .WriteData(WriteData),
        .ReadData(ReadData),
`ifdef INPUT_IRQ_EN
        .Irq(Irq),
`endif
        .ReadHit(ReadHit)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_bus();
        MemRead = 1'b0; MemWrite = 1'b0; Address = '0; WriteData = '0;
    endtask

    // Status read is combinational; bus returns to idle afterwards without an edge.
    task automatic read_status(output logic [31:0] v);
        Address = STAT_ADDR; MemRead = 1'b1; #1;
        v = ReadData;
        idle_bus(); #1;
    endtask

    task automatic push_word(input logic [31:0] d);
        InData = d; InValid = 1'b1;
        step();
        InValid = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] s;
        Reset = 1'b1; #3;
        checks++;
        if (InReady !== 1'b0) $display("FAIL reset_inready got %0b want 0", InReady);
        else passed++;
        step(); Reset = 1'b0; #1;
        checks++;
        if (InReady !== 1'b1) $display("FAIL post_reset_inready got %0b want 1", InReady);
        else passed++;
        read_status(s);
        checks++;
        if (s !== 32'h0000_0001) $display("FAIL reset_status got %h want 00000001", s);
        else passed++;
        Address = 32'h0000_1000; MemRead = 1'b1; #1;
        checks++;
        if (ReadHit !== 1'b0 || ReadData !== 32'h0) $display("FAIL nohit got hit=%0b data=%h want 0/0", ReadHit, ReadData);
        else passed++;
        idle_bus();
    endtask

    task automatic test_fill();
        logic [31:0] s;
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (InReady !== 1'b1) $display("FAIL fill_ready_%0d got %0b want 1", i, InReady);
            else passed++;
            push_word(32'hA5A5_0000 + 32'(i));
        end
        checks++;
        if (InReady !== 1'b0) $display("FAIL full_inready got %0b want 0", InReady);
        else passed++;
        read_status(s);
        checks++;
        if (s !== 32'h0000_0402) $display("FAIL full_status got %h want 00000402", s);
        else passed++;
    endtask

    task automatic test_drain();
        logic [31:0] s;
        for (int i = 1; i <= 4; i++) begin
            Address = DATA_ADDR; MemRead = 1'b1; #1;
            checks++;
            if (ReadHit !== 1'b1 || ReadData !== 32'hA5A5_0000 + 32'(i))
                $display("FAIL drain_%0d got hit=%0b data=%h want 1/%h", i, ReadHit, ReadData, 32'hA5A5_0000 + 32'(i));
            else passed++;
            step();
            idle_bus();
        end
        read_status(s);
        checks++;
        if (s !== 32'h0000_0001) $display("FAIL drained_status got %h want 00000001", s);
        else passed++;
        checks++;
        if (InReady !== 1'b1) $display("FAIL drained_inready got %0b want 1", InReady);
        else passed++;
    endtask

    task automatic test_underflow();
        logic [31:0] s;
        Address = DATA_ADDR; MemRead = 1'b1; #1;
        checks++;
        if (ReadHit !== 1'b1 || ReadData !== 32'h0) $display("FAIL empty_load got hit=%0b data=%h want 1/0", ReadHit, ReadData);
        else passed++;
        step(); idle_bus();
        read_status(s);
        checks++;
        if (s !== 32'h0000_0005) $display("FAIL underflow_status got %h want 00000005", s);
        else passed++;
        // Store to DATA_ADDR must not disturb anything.
        Address = DATA_ADDR; MemWrite = 1'b1; WriteData = 32'h4; step(); idle_bus();
        // Store with bit2 clear must not clear Underflow.
        Address = STAT_ADDR; MemWrite = 1'b1; WriteData = 32'hFFFF_FFFB; step(); idle_bus();
        read_status(s);
        checks++;
        if (s !== 32'h0000_0005) $display("FAIL nonclear_status got %h want 00000005", s);
        else passed++;
        Address = STAT_ADDR; MemWrite = 1'b1; WriteData = 32'h4; step(); idle_bus();
        read_status(s);
        checks++;
        if (s !== 32'h0000_0001) $display("FAIL cleared_status got %h want 00000001", s);
        else passed++;
        // Load on empty plus clear store in the same cycle is not possible; check set-over-hold via MemRead+MemWrite.
        Address = DATA_ADDR; MemRead = 1'b1; MemWrite = 1'b1; WriteData = 32'h4; step(); idle_bus();
        read_status(s);
        checks++;
        if (s !== 32'h0000_0005) $display("FAIL rw_both_status got %h want 00000005", s);
        else passed++;
        Address = STAT_ADDR; MemWrite = 1'b1; WriteData = 32'h4; step(); idle_bus();
    endtask

    task automatic test_back_to_back();
        logic [31:0] s;
        push_word(32'hB000_0001);
        push_word(32'hB000_0002);
        InData = 32'hB000_0003; InValid = 1'b1;
        Address = DATA_ADDR; MemRead = 1'b1; #1;
        checks++;
        if (ReadData !== 32'hB000_0001) $display("FAIL same_edge_data got %h want B0000001", ReadData);
        else passed++;
        step(); InValid = 1'b0; idle_bus();
        read_status(s);
        checks++;
        if (s !== 32'h0000_0200) $display("FAIL same_edge_status got %h want 00000200", s);
        else passed++;
        for (int i = 2; i <= 3; i++) begin
            Address = DATA_ADDR; MemRead = 1'b1; #1;
            checks++;
            if (ReadData !== 32'hB000_0000 + 32'(i)) $display("FAIL order_%0d got %h want %h", i, ReadData, 32'hB000_0000 + 32'(i));
            else passed++;
            step(); idle_bus();
        end
        // Fill, then hold a fifth word on the input while popping once.
        for (int i = 1; i <= 4; i++) push_word(32'hC000_0000 + 32'(i));
        InData = 32'hC000_0005; InValid = 1'b1;
        step();
        checks++;
        if (InReady !== 1'b0) $display("FAIL held_full_ready got %0b want 0", InReady);
        else passed++;
        Address = DATA_ADDR; MemRead = 1'b1; #1;
        checks++;
        if (ReadData !== 32'hC000_0001) $display("FAIL full_pop_data got %h want C0000001", ReadData);
        else passed++;
        step(); idle_bus();
        checks++;
        if (InReady !== 1'b1) $display("FAIL after_pop_ready got %0b want 1", InReady);
        else passed++;
        step();
        checks++;
        if (InReady !== 1'b0) $display("FAIL refill_ready got %0b want 0", InReady);
        else passed++;
        step(); InValid = 1'b0;
        read_status(s);
        checks++;
        if (s !== 32'h0000_0402) $display("FAIL refill_status got %h want 00000402", s);
        else passed++;
        for (int i = 2; i <= 5; i++) begin
            Address = DATA_ADDR; MemRead = 1'b1; #1;
            checks++;
            if (ReadData !== 32'hC000_0000 + 32'(i)) $display("FAIL full_order_%0d got %h want %h", i, ReadData, 32'hC000_0000 + 32'(i));
            else passed++;
            step(); idle_bus();
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] s;
        for (int i = 1; i <= 3; i++) push_word(32'hD000_0000 + 32'(i));
        InData = 32'hD000_0004; InValid = 1'b1;
        #2 Reset = 1'b1; #1;
        checks++;
        if (InReady !== 1'b0) $display("FAIL midreset_ready got %0b want 0", InReady);
        else passed++;
        read_status(s);
        checks++;
        if (s !== 32'h0000_0001) $display("FAIL midreset_status got %h want 00000001", s);
        else passed++;
        InValid = 1'b0;
        step(); Reset = 1'b0; #1;
        Address = DATA_ADDR; MemRead = 1'b1; #1;
        checks++;
        if (ReadData !== 32'h0) $display("FAIL postreset_load got %h want 0", ReadData);
        else passed++;
        step(); idle_bus();
        read_status(s);
        checks++;
        if (s !== 32'h0000_0005) $display("FAIL postreset_status got %h want 00000005", s);
        else passed++;
        Address = STAT_ADDR; MemWrite = 1'b1; WriteData = 32'h4; step(); idle_bus();
    endtask

`ifdef INPUT_IRQ_EN
    task automatic test_irq();
        checks++;
        if (Irq !== 1'b0) $display("FAIL irq_idle got %0b want 0", Irq);
        else passed++;
        push_word(32'hE000_0001);
        checks++;
        if (Irq !== 1'b0) $display("FAIL irq_one got %0b want 0", Irq);
        else passed++;
        push_word(32'hE000_0002);
        checks++;
        if (Irq !== 1'b1) $display("FAIL irq_two got %0b want 1", Irq);
        else passed++;
        Address = DATA_ADDR; MemRead = 1'b1; step(); idle_bus();
        checks++;
        if (Irq !== 1'b0) $display("FAIL irq_drop got %0b want 0", Irq);
        else passed++;
        Address = DATA_ADDR; MemRead = 1'b1; step(); idle_bus();
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_underflow();
        test_back_to_back();
        test_reset_mid();
`ifdef INPUT_IRQ_EN
        test_irq();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
